// File: rtl/checkpoint_tx_if.sv
// Write port and checkpoint bus bundle for checkpoint_tx.
// master: management side / observer, slave: checkpoint_tx itself.
interface checkpoint_tx_if #(
  parameter int CODE_W = 16
);
  logic              wr_valid;
  logic              wr_ready;
  logic [CODE_W-1:0] wr_code;
  logic [CODE_W-1:0] check_out;
  logic              check_oe;
  logic              busy;
  logic [31:0]       kcycles;
  logic              perf_running;
  logic              perf_done;

  modport master (
    output wr_valid, wr_code,
    input  wr_ready, check_out, check_oe, busy, kcycles, perf_running, perf_done
  );

  modport slave (
    input  wr_valid, wr_code,
    output wr_ready, check_out, check_oe, busy, kcycles, perf_running, perf_done
  );
endinterface

// File: rtl/checkpoint_tx.sv
// Buffers checkpoint codes, holds each on the pad bus for a minimum time,
// and times the START..DONE interval in KDIV-cycle units.
//
// state | meaning
// IDLE  | nothing being held; pop as soon as the FIFO has an entry
// HOLD  | current code on check_out, hold_cnt_q counting down to next pop
module checkpoint_tx #(
  parameter int                CODE_W      = 16,
  parameter int                DEPTH       = 4,
  parameter int                HOLD_CYCLES = 8,
  parameter logic [CODE_W-1:0] START_CODE  = 16'hA000,
  parameter logic [CODE_W-1:0] DONE_CODE   = 16'hAB00,
  parameter int                KDIV        = 1000
) (
  input logic           clock,
  input logic           resetb,
  checkpoint_tx_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int SW = $clog2(KDIV);
  localparam logic [HW-1:0] HOLD_RELOAD = HW'(HOLD_CYCLES - 1);
  localparam logic [SW-1:0] SUB_MAX     = SW'(KDIV - 1);
  localparam logic [AW:0]   FULL_COUNT  = (AW + 1)'(DEPTH);

  typedef enum logic {IDLE, HOLD} state_t;

  logic [CODE_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     rd_ptr_q, wr_ptr_q;
  logic [AW:0]       count_q;
  state_t            state_q;
  logic [HW-1:0]     hold_cnt_q;
  logic [CODE_W-1:0] check_out_q;
  logic              check_oe_q;
  logic [31:0]       kcycles_q, kcycles_d;
  logic [SW-1:0]     sub_q, sub_d;
  logic              running_q, running_d;
  logic              done_q, done_d;

  logic              fifo_empty, fifo_full, push, pop;
  logic [CODE_W-1:0] head;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == FULL_COUNT);
  // Ready depends only on registered occupancy, so a same-cycle pop never frees a slot.
  assign push       = bus.wr_valid & ~fifo_full;
  assign pop        = ~fifo_empty & ((state_q == IDLE) | (hold_cnt_q == '0));
  assign head       = mem_q[rd_ptr_q];

  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= bus.wr_code;
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state_q     <= IDLE;
      hold_cnt_q  <= '0;
      check_out_q <= '0;
      check_oe_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (pop) begin
            check_out_q <= head;
            check_oe_q  <= 1'b1;
            hold_cnt_q  <= HOLD_RELOAD;
            state_q     <= HOLD;
          end
        end
        HOLD: begin
          if (hold_cnt_q != '0) begin
            hold_cnt_q <= hold_cnt_q - 1'b1;
          end else if (pop) begin
            check_out_q <= head;
            hold_cnt_q  <= HOLD_RELOAD;
          end else begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // A START pop overrides the running increment, giving restart semantics.
  always_comb begin
    kcycles_d = kcycles_q;
    sub_d     = sub_q;
    running_d = running_q;
    done_d    = done_q;
    if (running_q) begin
      if (sub_q == SUB_MAX) begin
        sub_d = '0;
        if (kcycles_q != '1) kcycles_d = kcycles_q + 32'd1;
      end else begin
        sub_d = sub_q + 1'b1;
      end
    end
    if (pop && (head == START_CODE)) begin
      kcycles_d = '0;
      sub_d     = '0;
      running_d = 1'b1;
      done_d    = 1'b0;
    end else if (pop && (head == DONE_CODE) && running_q) begin
      running_d = 1'b0;
      done_d    = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      kcycles_q <= '0;
      sub_q     <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      kcycles_q <= kcycles_d;
      sub_q     <= sub_d;
      running_q <= running_d;
      done_q    <= done_d;
    end
  end

  assign bus.wr_ready     = ~fifo_full;
  assign bus.check_out    = check_out_q;
  assign bus.check_oe     = check_oe_q;
  assign bus.busy         = ~fifo_empty | (state_q == HOLD);
  assign bus.kcycles      = kcycles_q;
  assign bus.perf_running = running_q;
  assign bus.perf_done    = done_q;
endmodule

// File: tb/tb_checkpoint_tx.sv
// Bench for checkpoint_tx: directed scenarios plus a random phase, compared
// each cycle against a pop-schedule model of the checkpoint bus.
module tb_checkpoint_tx;
  localparam int          CODE_W = 16;
  localparam int          DEPTH  = 4;
  localparam int          HOLD   = 8;
  localparam int          KDIV   = 10;
  localparam logic [15:0] START  = 16'hA000;
  localparam logic [15:0] DONE   = 16'hAB00;

  logic clock  = 1'b0;
  logic resetb = 1'b0;

  checkpoint_tx_if #(.CODE_W(CODE_W)) bus ();

  checkpoint_tx #(
    .CODE_W(CODE_W), .DEPTH(DEPTH), .HOLD_CYCLES(HOLD),
    .START_CODE(START), .DONE_CODE(DONE), .KDIV(KDIV)
  ) dut (
    .clock (clock),
    .resetb(resetb),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [15:0] code;
    int          pop_at;
  } entry_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc   = 0;
  entry_t      pend[$];
  int          sched_last, last_pop;
  logic [15:0] m_out;
  logic        m_oe, m_run, m_done;
  int          m_start, m_end;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    pend.delete();
    sched_last = -1000;
    last_pop   = -1000;
    m_out      = '0;
    m_oe       = 1'b0;
    m_run      = 1'b0;
    m_done     = 1'b0;
    m_start    = 0;
    m_end      = 0;
  endtask

  function automatic logic model_busy();
    return (pend.size() > 0) || (cyc < last_pop + HOLD);
  endfunction

  function automatic logic [31:0] model_kcycles();
    if (m_run)  return 32'((cyc - m_start) / KDIV);
    if (m_done) return 32'((m_end - m_start) / KDIV);
    return 32'd0;
  endfunction

  task automatic compare_all();
    check("check_out",    bus.check_out,    m_out);
    check("check_oe",     bus.check_oe,     m_oe);
    check("busy",         bus.busy,         model_busy());
    check("wr_ready",     bus.wr_ready,     pend.size() < DEPTH);
    check("kcycles",      bus.kcycles,      model_kcycles());
    check("perf_running", bus.perf_running, m_run);
    check("perf_done",    bus.perf_done,    m_done);
  endtask

  // One clock edge: the model decides acceptance and pop edges from the schedule.
  task automatic tick();
    logic   acc;
    entry_t e;
    acc = resetb && bus.wr_valid && (pend.size() < DEPTH);
    e.code = bus.wr_code;
    @(posedge clock);
    cyc++;
    if (acc) begin
      e.pop_at   = (cyc + 1 > sched_last + HOLD) ? cyc + 1 : sched_last + HOLD;
      sched_last = e.pop_at;
      pend.push_back(e);
    end
    if (pend.size() > 0 && pend[0].pop_at == cyc) begin
      e        = pend.pop_front();
      m_out    = e.code;
      m_oe     = 1'b1;
      last_pop = cyc;
      if (e.code == START) begin
        m_run   = 1'b1;
        m_done  = 1'b0;
        m_start = cyc;
      end else if (e.code == DONE && m_run) begin
        m_run  = 1'b0;
        m_done = 1'b1;
        m_end  = cyc;
      end
    end
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic push(input logic [15:0] code);
    logic got;
    got = 1'b0;
    bus.wr_valid = 1'b1;
    bus.wr_code  = code;
    for (int i = 0; i < 64 && !got; i++) begin
      got = (pend.size() < DEPTH);
      tick();
    end
    bus.wr_valid = 1'b0;
    check("push_accepted", got, 1'b1);
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && model_busy(); i++) tick();
    check("drain_idle", bus.busy, 1'b0);
  endtask

  initial begin
    bus.wr_valid = 1'b0;
    bus.wr_code  = '0;
    model_reset();
    #2;
    check("rst_check_out", bus.check_out,    16'h0);
    check("rst_check_oe",  bus.check_oe,     1'b0);
    check("rst_busy",      bus.busy,         1'b0);
    check("rst_kcycles",   bus.kcycles,      32'd0);
    check("rst_running",   bus.perf_running, 1'b0);
    check("rst_done",      bus.perf_done,    1'b0);
    check("rst_wr_ready",  bus.wr_ready,     1'b1);
    #10 resetb = 1'b1;

    // Single code: visible one edge after push, busy drops after edge 9.
    push(16'h1234);
    tick();
    check("t1_out", bus.check_out, 16'h1234);
    check("t1_oe",  bus.check_oe,  1'b1);
    idle(7);
    check("t1_busy_e8", bus.busy, 1'b1);
    tick();
    check("t1_busy_e9", bus.busy, 1'b0);

    // Back-to-back codes, including a repeated identical one.
    drain();
    push(16'h0001);
    push(16'h0002);
    push(16'h0003);
    push(16'h0003);
    drain();

    // Backpressure: one active plus DEPTH queued.
    for (int i = 0; i < 5; i++) push(16'h0100 + 16'(i));
    check("t3_full_ready", bus.wr_ready, 1'b0);
    push(16'h0105);
    drain();

    // Measurement: START and DONE pushed 40 edges apart.
    push(START);
    tick();
    check("t4_running", bus.perf_running, 1'b1);
    idle(38);
    push(DONE);
    tick();
    check("t4_done",    bus.perf_done,    1'b1);
    check("t4_kcycles", bus.kcycles,      32'd4);
    check("t4_stopped", bus.perf_running, 1'b0);
    drain();

    // Async reset mid-measurement with three codes queued.
    push(START);
    push(16'h0202);
    push(16'h0203);
    push(16'h0204);
    idle(2);
    #3 resetb = 1'b0;
    model_reset();
    #1;
    check("t6_out",     bus.check_out,    16'h0);
    check("t6_oe",      bus.check_oe,     1'b0);
    check("t6_busy",    bus.busy,         1'b0);
    check("t6_kcycles", bus.kcycles,      32'd0);
    check("t6_running", bus.perf_running, 1'b0);
    idle(2);
    #3 resetb = 1'b1;
    idle(20);
    check("t6_oe_after", bus.check_oe, 1'b0);

    // Stray DONE, then restart by a second START.
    push(DONE);
    drain();
    check("t5_stray_done", bus.perf_done, 1'b0);
    push(START);
    idle(24);
    push(START);
    idle(29);
    push(DONE);
    idle(10);
    check("t5_kcycles", bus.kcycles,   32'd3);
    check("t5_done",    bus.perf_done, 1'b1);
    drain();

    // Random traffic with START/DONE sprinkled in.
    for (int i = 0; i < 500; i++) begin
      bus.wr_valid = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 7))
        0:       bus.wr_code = START;
        1:       bus.wr_code = DONE;
        default: bus.wr_code = 16'($urandom);
      endcase
      tick();
    end
    bus.wr_valid = 1'b0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/checkpoint_tx.md
Name: checkpoint_tx

Overview:
Hardware source for the 16-bit checkpoint codes that the simulation monitor watches on mprj_io[31:16] (start 0xA000, done 0xAB00).
- Accepts codes from the management side through a valid/ready write port and buffers them in a small FIFO.
- Drives each code onto the checkpoint bus for a guaranteed minimum hold time, so that a sampling monitor never misses one.
- Measures, in hardware, the elapsed time between the start and done codes in units of KDIV cycles.

Parameters:
CODE_W, 16, checkpoint code width
DEPTH, 4, FIFO entries (power of 2, >=2)
HOLD_CYCLES, 8, minimum cycles each code stays on check_out (>=1)
START_CODE, 16'hA000, code that starts the performance counter
DONE_CODE, 16'hAB00, code that stops the performance counter
KDIV, 1000, cycles per kcycles increment (>=2)

Ports:
clock  in  1  single system clock, posedge
resetb  in  1  reset; asynchronous, active-low
wr_valid  in  1  code write request
wr_ready  out  1  FIFO can accept (= !full)
wr_code  in  CODE_W  code to emit
check_out  out  CODE_W  checkpoint bus value
check_oe  out  1  output enable for checkpoint pads
busy  out  1  FIFO non-empty or HOLD active
kcycles  out  32  elapsed KDIV-cycle units
perf_running  out  1  counter active
perf_done  out  1  START..DONE measurement complete (sticky)

Behaviour:
- Reset (async assert, sync release):
  - FIFO empty; state IDLE.
  - check_out=0, check_oe=0, busy=0, kcycles=0.
  - perf_running=0, perf_done=0; wr_ready=1 after reset.
- Write handshake: a push occurs on any edge with wr_valid & wr_ready. When full, wr_ready=0 even if a pop occurs in the same cycle (no bypass). Codes are never dropped or reordered.
- FSM states are IDLE and HOLD.
  - IDLE: if the FIFO is non-empty at the edge, pop the head into check_out, set check_oe=1, load hold_cnt=HOLD_CYCLES-1, go to HOLD.
  - HOLD: if hold_cnt!=0, decrement. If hold_cnt==0 and the FIFO is non-empty, pop the next code on this edge and reload (back-to-back, no gap). If hold_cnt==0 and the FIFO is empty, go to IDLE.
- Latency: a code pushed at edge N into an empty FIFO with the FSM in IDLE appears on check_out after edge N+1.
- Hold: each code is held for exactly HOLD_CYCLES cycles when the next code is queued. Otherwise it stays indefinitely; check_out is sticky.
- check_oe: rises with the first pop and stays 1 until reset.
- busy = FIFO non-empty | (state==HOLD).
- Perf counter (evaluated on the edge a code is popped onto check_out):
  - START_CODE popped: kcycles=0, sub=0, perf_running=1, perf_done=0. This also applies while already running (restart).
  - DONE_CODE popped while running: this edge still counts. Then perf_running=0, perf_done=1.
  - DONE_CODE popped while not running: ignored.
  - While running, on every edge after the START edge: sub increments. When sub reaches KDIV-1, sub wraps to 0 and kcycles increments.
  - kcycles saturates at 32'hFFFFFFFF and does not wrap.
  - Result: with D edges from the START pop to the DONE pop, final kcycles = floor(D/KDIV).
- A repeated identical code is still pushed and held as a separate entry; check_out shows no visible change.
- Reset mid-HOLD or mid-measurement: everything returns to its reset values and pending FIFO contents are discarded.

Test Plan:
1. Single code: push 0x1234 at edge 0 -> check_out=0x1234 and check_oe=1 after edge 1; value held; busy=0 after edge 9 (HOLD_CYCLES=8).
2. Back-to-back: push 0x0001, 0x0002, 0x0003 on consecutive edges -> check_out changes after edges 1, 9 and 17; each value is stable for exactly 8 cycles.
3. Backpressure: hold wr_valid with no pops possible until the FIFO is full (4 queued behind the active code) -> wr_ready=0. After the next pop, wr_ready=1 and the fifth push is accepted; the output order matches push order.
4. Performance measurement (KDIV=10): push 0xA000 at edge 0 and 0xAB00 at edge 40 -> perf_running=1 after edge 1, perf_done=1 and kcycles=4 after edge 41, perf_running=0.
5. Stray DONE and restart: push 0xAB00 with no prior START -> perf_done stays 0. Push START, wait 25 cycles, push START again, then DONE 30 cycles later -> kcycles=3.
6. Reset mid-operation: assert resetb low asynchronously during HOLD with 3 entries queued -> check_out=0, check_oe=0, busy=0 and kcycles=0 immediately; no queued code appears after release.
